// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always driven on data_out.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int DATA_WIDTH      = 256,
  parameter int FIFO_DEPTH      = 256,
  parameter int FIFO_DEPTH_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       re_en,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       empty,
  output logic                       full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                       overflow,
  output logic                       underflow,
`endif
  output logic [FIFO_DEPTH_LOG2:0]   count
);

  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                       do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);
  assign count = cnt_q;
  assign do_wr = wr_en & ~full;
  assign do_rd = re_en & ~empty;

  // Asynchronous head read so a freshly written word is visible the cycle after its edge.
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_wr && !do_rd)      cnt_d = cnt_q + CNT_ONE;
    else if (do_rd && !do_wr) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is never cleared; reset only blocks a coincident write.
  always_ff @(posedge clk) begin
    if (!resetn && do_wr) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A read paired with a write into an empty FIFO is absorbed, not flagged.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & full);
    underflow_d = underflow_q | (re_en & empty & ~wr_en);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at DATA_WIDTH=8, FIFO_DEPTH=4.
// Error-flag checks are compiled in only when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int LOG2 = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          re_en;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic [LOG2:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sync_fifo #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .FIFO_DEPTH_LOG2(LOG2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .re_en    (re_en),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] exp_cnt, input logic [31:0] exp_head);
    chk({tag, ".count"}, 32'(count), exp_cnt);
    chk({tag, ".empty"}, 32'(empty), (exp_cnt == 0) ? 32'd1 : 32'd0);
    chk({tag, ".full"},  32'(full),  (exp_cnt == DEPTH) ? 32'd1 : 32'd0);
    chk({tag, ".head"},  32'(data_out), exp_head);
  endtask

  initial begin
    resetn = 1'b1; wr_en = 1'b1; re_en = 1'b0; data_in = 8'hAA;
    #1;
    // Reset held for 3 edges while a write is requested.
    repeat (3) step();
    resetn = 1'b0; wr_en = 1'b0;
    chk_state("reset", 0, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("reset.ovf", 32'(overflow), 0);
    chk("reset.udf", 32'(underflow), 0);
`endif

    // FWFT ordering.
    wr_en = 1'b1; data_in = 8'h11; step();
    chk_state("fwft.first", 1, 'h11);
    data_in = 8'h22; step();
    data_in = 8'h33; step();
    wr_en = 1'b0;
    chk_state("fwft.three", 3, 'h11);
    re_en = 1'b1;
    step(); chk_state("fwft.pop1", 2, 'h22);
    step(); chk_state("fwft.pop2", 1, 'h33);
    step(); chk_state("fwft.pop3", 0, 0);
    re_en = 1'b0;

    // Fill past full; the fifth word is dropped.
    wr_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data_in = 8'(i);
      step();
      if (i == 4) chk_state("full.4th", 4, 'h01);
    end
    wr_en = 1'b0;
    chk_state("full.5th", 4, 'h01);
`ifdef FIFO_ERR_FLAGS_EN
    chk("full.ovf", 32'(overflow), 1);
`endif
    re_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("full.pop%0d", i), 32'(data_out), 32'(i));
      step();
    end
    re_en = 1'b0;
    chk_state("full.drained", 0, 0);

    // Push+pop while empty: write wins, no underflow.
    wr_en = 1'b1; re_en = 1'b1; data_in = 8'h5A; step();
    chk_state("simul.empty", 1, 'h5A);
`ifdef FIFO_ERR_FLAGS_EN
    chk("simul.udf", 32'(underflow), 0);
`endif
    re_en = 1'b0;
    data_in = 8'h5B; step();
    data_in = 8'h5C; step();
    data_in = 8'h5D; step();
    chk_state("simul.filled", 4, 'h5A);
    // Push+pop while full: head advances, write dropped.
    re_en = 1'b1; data_in = 8'hEE; step();
    chk_state("simul.full", 3, 'h5B);
    wr_en = 1'b0;
    step(); chk_state("simul.d1", 2, 'h5C);
    step(); chk_state("simul.d2", 1, 'h5D);
    step(); chk_state("simul.d3", 0, 0);
    // Pop while empty is ignored.
    step(); chk_state("rd_empty", 0, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rd_empty.udf", 32'(underflow), 1);
`endif
    re_en = 1'b0;

    // Wrap-around at steady occupancy 2.
    wr_en = 1'b1;
    data_in = 8'h80; step();
    data_in = 8'h81; step();
    re_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'(8'h82 + i);
      step();
      chk_state($sformatf("wrap%0d", i), 2, 32'(8'h81 + i));
    end
    re_en = 1'b0;
    data_in = 8'h99; step();
    wr_en = 1'b0;
    chk_state("midrst.pre", 3, 'h8A);

    // Reset mid-operation discards everything.
    resetn = 1'b1; step();
    resetn = 1'b0;
    chk_state("midrst.post", 0, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("midrst.ovf", 32'(overflow), 0);
    chk("midrst.udf", 32'(underflow), 0);
`endif
    wr_en = 1'b1; data_in = 8'h77; step();
    wr_en = 1'b0;
    chk_state("midrst.push", 1, 'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, first-word-fall-through (FWFT) FIFO with parameterised width and depth.
The head entry is always visible on data_out without a read strobe. Asserting re_en pops the head.
Used to queue expected results, for example 256-bit reference hashes, alongside a fixed-latency datapath. The consumer compares data_out against the datapath result and pops on a match.

Parameters:
- DATA_WIDTH, 256, bit width of each entry.
- FIFO_DEPTH, 256, number of entries. Must equal 2**FIFO_DEPTH_LOG2.
- FIFO_DEPTH_LOG2, 8, pointer width in bits.

Ports:
- clk  input  1  rising-edge clock for all state.
- resetn  input  1  reset, synchronous, active-high: asserted = 1, sampled on the rising clk edge.
- re_en  input  1  pop request for the head entry.
- wr_en  input  1  push request for data_in.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  head entry, FWFT.
- empty  output  1  high when the FIFO holds 0 entries.
- full  output  1  high when the FIFO holds FIFO_DEPTH entries.
- count  output  FIFO_DEPTH_LOG2+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Storage: memory array of FIFO_DEPTH x DATA_WIDTH. Write pointer wr_ptr and read pointer rd_ptr are each FIFO_DEPTH_LOG2 bits. An occupancy register cnt is FIFO_DEPTH_LOG2+1 bits.
- Reset (resetn=1 at a clk edge):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - empty=1, full=0, count=0, data_out=0.
  - Memory contents are not cleared.
  - Reset has priority over any simultaneous wr_en or re_en.
- Write accept: do_wr = wr_en & ~full. On accept, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read accept: do_rd = re_en & ~empty. On accept, rd_ptr increments.
- Pointer wrap-around: pointers wrap naturally from FIFO_DEPTH-1 to 0 through modulo-2**LOG2 arithmetic.
- Occupancy update on each edge:
  - cnt + 1 if do_wr & ~do_rd.
  - cnt - 1 if do_rd & ~do_wr.
  - unchanged otherwise.
- Flags are combinational from the registered cnt: empty = (cnt==0), full = (cnt==FIFO_DEPTH), count = cnt.
- data_out = empty ? 0 : mem[rd_ptr]. This is a combinational (asynchronous) read of the head.
- Latency:
  - A word written at edge N appears on data_out, with empty=0, after edge N (visible during cycle N+1).
  - A pop at edge N presents the next entry after edge N.
- Simultaneous wr_en & re_en:
  - Not empty and not full: both accepted, cnt unchanged, pointers both advance.
  - Empty: write accepted, read ignored. cnt becomes 1 and no underflow occurs.
  - Full: read accepted, write dropped. cnt becomes FIFO_DEPTH-1.
- Write while full (re_en=0): dropped. Memory and pointers unchanged.
- Read while empty: ignored. Pointers unchanged.
- Reset mid-operation: all queued entries are discarded in one cycle. The FIFO is empty the next cycle.
- Inputs are treated as don't-care while resetn=1.

Optional Feature:
Macro: FIFO_ERR_FLAGS_EN.
- Defined: adds two outputs, overflow (1 bit) and underflow (1 bit).
  - Both are sticky registers, cleared only by reset.
  - overflow sets at an edge where wr_en=1, full=1 and the write is dropped. A write accepted together with a pop never sets overflow.
  - underflow sets at an edge where re_en=1 and empty=1.
  - Flags are visible the cycle after the offending edge.
- Not defined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: hold resetn=1 for 3 edges with wr_en=1, data_in=8'hAA.
  - Response: empty=1, full=0, count=0, data_out=0 after release.
- FWFT ordering (DATA_WIDTH=8, FIFO_DEPTH=4, LOG2=2):
  - Stimulus: push 8'h11, 8'h22, 8'h33 on consecutive edges.
  - Response: data_out=8'h11 one cycle after the first push. Pops then yield 8'h22, 8'h33, then empty=1.
- Full and drop:
  - Stimulus: push 8'h01..8'h05 with depth 4.
  - Response: full=1 and count=4 after the 4th push. 8'h05 is dropped. Pops return 01, 02, 03, 04. overflow=1 when FIFO_ERR_FLAGS_EN is defined.
- Simultaneous at boundaries:
  - Stimulus: wr_en=re_en=1 while empty with data_in=8'h5A.
  - Response: count=1, data_out=8'h5A, no underflow.
  - Stimulus: wr_en=re_en=1 while full.
  - Response: count=3, head advances, write dropped.
- Wrap-around:
  - Stimulus: 10 cycles of push+pop at steady occupancy 2 with an incrementing data pattern.
  - Response: pointers wrap past 3 and data_out follows strict FIFO order throughout.
- Reset mid-operation:
  - Stimulus: fill to 3 entries, assert resetn=1 for 1 edge.
  - Response: empty=1, count=0. The next push of 8'h77 appears on data_out.
